// File: rtl/gate_vector_checker_if.sv
// Bundle between a gate vector source and the checker: run control, vector
// stream and result outputs.
interface gate_vector_checker_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] num_vec;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic             a;
    logic             b;
    logic [2:0]       y;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic             mismatch;
    logic [2:0]       mismatch_bits;
    logic [4:0]       last_fail_vec;
    logic             busy;
    logic             done;

    modport master (
        output start, num_vec, clear, in_valid, a, b, y,
        input  in_ready, pass_cnt, fail_cnt, mismatch, mismatch_bits,
               last_fail_vec, busy, done
    );

    modport slave (
        input  start, num_vec, clear, in_valid, a, b, y,
        output in_ready, pass_cnt, fail_cnt, mismatch, mismatch_bits,
               last_fail_vec, busy, done
    );
endinterface

// File: rtl/gate_vector_checker.sv
// Checks observed {AND, OR, NOT a} gate outputs against their operands for a
// run of num_vec vectors, counting passes/fails and capturing the last failure.
module gate_vector_checker #(
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gate_vector_checker_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_reg;
    logic [CNT_W-1:0] num_vec_reg;
    logic [CNT_W-1:0] acc_cnt_reg;
    logic [CNT_W-1:0] pass_cnt_reg;
    logic [CNT_W-1:0] fail_cnt_reg;
    logic             mismatch_reg;
    logic [2:0]       mismatch_bits_reg;
    logic [4:0]       last_fail_vec_reg;

    logic [2:0] expected;
    logic       accept;
    logic       vec_fail;
    logic       last_accept;

    assign expected    = {bus.a & bus.b, bus.a | bus.b, ~bus.a};
    // Ready depends on state only so the source may wait on it before raising valid.
    assign bus.in_ready = (state_reg == RUN) && (acc_cnt_reg < num_vec_reg);
    assign accept      = bus.in_valid && bus.in_ready;
    assign vec_fail    = (bus.y != expected);
    assign last_accept = accept && ((acc_cnt_reg + CNT_ONE) == num_vec_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            num_vec_reg       <= '0;
            acc_cnt_reg       <= '0;
            pass_cnt_reg      <= '0;
            fail_cnt_reg      <= '0;
            mismatch_reg      <= 1'b0;
            mismatch_bits_reg <= '0;
            last_fail_vec_reg <= '0;
        end else if (bus.clear) begin
            state_reg         <= IDLE;
            acc_cnt_reg       <= '0;
            pass_cnt_reg      <= '0;
            fail_cnt_reg      <= '0;
            mismatch_reg      <= 1'b0;
            mismatch_bits_reg <= '0;
            last_fail_vec_reg <= '0;
        end else begin
            mismatch_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (bus.start) begin
                        num_vec_reg       <= bus.num_vec;
                        acc_cnt_reg       <= '0;
                        pass_cnt_reg      <= '0;
                        fail_cnt_reg      <= '0;
                        mismatch_bits_reg <= '0;
                        last_fail_vec_reg <= '0;
                        state_reg         <= (bus.num_vec == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        acc_cnt_reg <= acc_cnt_reg + CNT_ONE;
                        if (vec_fail) begin
                            fail_cnt_reg      <= (fail_cnt_reg == CNT_MAX) ? fail_cnt_reg
                                                                           : fail_cnt_reg + CNT_ONE;
                            mismatch_reg      <= 1'b1;
                            mismatch_bits_reg <= bus.y ^ expected;
                            last_fail_vec_reg <= {bus.a, bus.b, bus.y};
                        end else begin
                            pass_cnt_reg <= (pass_cnt_reg == CNT_MAX) ? pass_cnt_reg
                                                                      : pass_cnt_reg + CNT_ONE;
                        end
                        if (last_accept) begin
                            state_reg <= DONE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.pass_cnt      = pass_cnt_reg;
    assign bus.fail_cnt      = fail_cnt_reg;
    assign bus.mismatch      = mismatch_reg;
    assign bus.mismatch_bits = mismatch_bits_reg;
    assign bus.last_fail_vec = last_fail_vec_reg;
    assign bus.busy          = (state_reg == RUN);
    assign bus.done          = (state_reg == DONE);
endmodule

// File: tb/tb_gate_vector_checker.sv
// Randomized and directed bench for gate_vector_checker with a run-level model.
module tb_gate_vector_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gate_vector_checker_if #(.CNT_W(8)) bus ();
    gate_vector_checker_if #(.CNT_W(2)) bus2 ();

    gate_vector_checker #(.CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    gate_vector_checker #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int errors = 0;
    int checks = 0;

    // Run-level model: how many vectors were taken and what they scored.
    int         m_n, m_acc, m_pass, m_fail;
    bit         m_mis, m_run, m_done;
    logic [2:0] m_mbits;
    logic [4:0] m_lfv;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_acc = 0; m_pass = 0; m_fail = 0; m_mis = 0; m_mbits = '0; m_lfv = '0;
    endtask

    task automatic start_run(input int n);
        bus.start = 1'b1;
        bus.num_vec = 8'(n);
        tick();
        bus.start = 1'b0;
        model_clear();
        m_n = n;
        m_run = (n != 0);
        m_done = (n == 0);
    endtask

    task automatic feed(input bit v, input bit a, input bit b, input logic [2:0] y);
        bit         take;
        logic [2:0] e;
        bus.in_valid = v; bus.a = a; bus.b = b; bus.y = y;
        take = v && m_run && (m_acc < m_n);
        e = {a & b, a | b, !a};
        tick();
        bus.in_valid = 1'b0;
        m_mis = 0;
        if (take) begin
            m_acc++;
            if (y == e) m_pass++;
            else begin
                m_fail++; m_mis = 1; m_mbits = y ^ e; m_lfv = {a, b, y};
            end
            if (m_acc == m_n) begin m_run = 0; m_done = 1; end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({bus.in_ready, bus.busy, bus.done, bus.mismatch, bus.pass_cnt, bus.fail_cnt,
             bus.mismatch_bits, bus.last_fail_vec} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b busy=%b done=%b mis=%b pass=%0d fail=%0d mb=%b lfv=%b required all 0",
                     bus.in_ready, bus.busy, bus.done, bus.mismatch, bus.pass_cnt, bus.fail_cnt,
                     bus.mismatch_bits, bus.last_fail_vec);
        end
        checks++;
        if ({bus2.busy, bus2.done, bus2.pass_cnt, bus2.fail_cnt} !== 6'd0) begin
            errors++;
            $display("FAIL reset_outputs_w2: got busy=%b done=%b pass=%0d fail=%0d required 0",
                     bus2.busy, bus2.done, bus2.pass_cnt, bus2.fail_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        m_run = 0; m_done = 0; model_clear();
    endtask

    task automatic test_back_to_back();
        logic [2:0] ys [4];
        ys = '{3'b001, 3'b011, 3'b010, 3'b110};
        start_run(4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready vec%0d: got %b required 1", i, bus.in_ready);
            end
            feed(1'b1, i[1], i[0], ys[i]);
            if (i == 2) begin
                checks++;
                if ({bus.done, bus.busy, bus.pass_cnt} !== {1'b0, 1'b1, 8'd3}) begin
                    errors++;
                    $display("FAIL b2b_mid: got done=%b busy=%b pass=%0d required 0 1 3",
                             bus.done, bus.busy, bus.pass_cnt);
                end
            end
        end
        checks++;
        if ({bus.pass_cnt, bus.fail_cnt, bus.done, bus.busy, bus.in_ready, bus.mismatch}
            !== {8'd4, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_end: got pass=%0d fail=%0d done=%b busy=%b rdy=%b mis=%b required 4 0 1 0 0 0",
                     bus.pass_cnt, bus.fail_cnt, bus.done, bus.busy, bus.in_ready, bus.mismatch);
        end
    endtask

    task automatic test_one_fail();
        start_run(2);
        feed(1'b1, 1'b1, 1'b1, 3'b111);
        checks++;
        if ({bus.mismatch, bus.mismatch_bits, bus.last_fail_vec, bus.fail_cnt}
            !== {1'b1, 3'b001, 5'b11111, 8'd1}) begin
            errors++;
            $display("FAIL fail_capture: got mis=%b mb=%b lfv=%b fail=%0d required 1 001 11111 1",
                     bus.mismatch, bus.mismatch_bits, bus.last_fail_vec, bus.fail_cnt);
        end
        feed(1'b1, 1'b0, 1'b0, 3'b001);
        checks++;
        if ({bus.mismatch, bus.mismatch_bits, bus.last_fail_vec, bus.pass_cnt, bus.fail_cnt, bus.done}
            !== {1'b0, 3'b001, 5'b11111, 8'd1, 8'd1, 1'b1}) begin
            errors++;
            $display("FAIL fail_hold: got mis=%b mb=%b lfv=%b pass=%0d fail=%0d done=%b required 0 001 11111 1 1 1",
                     bus.mismatch, bus.mismatch_bits, bus.last_fail_vec, bus.pass_cnt, bus.fail_cnt, bus.done);
        end
    endtask

    task automatic test_gapped_valid();
        bit pat [7];
        bit a, b;
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        start_run(3);
        for (int i = 0; i < 7; i++) begin
            a = 1'($urandom); b = 1'($urandom);
            feed(pat[i], a, b, {a & b, a | b, !a});
        end
        checks++;
        if ({bus.pass_cnt, bus.fail_cnt, bus.done, bus.in_ready} !== {8'd3, 8'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL gapped_valid: got pass=%0d fail=%0d done=%b rdy=%b required 3 0 1 0",
                     bus.pass_cnt, bus.fail_cnt, bus.done, bus.in_ready);
        end
    endtask

    task automatic test_zero_restart();
        start_run(0);
        checks++;
        if ({bus.done, bus.busy, bus.in_ready, bus.pass_cnt, bus.fail_cnt} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL zero_run: got done=%b busy=%b rdy=%b pass=%0d fail=%0d required 1 0 0 0 0",
                     bus.done, bus.busy, bus.in_ready, bus.pass_cnt, bus.fail_cnt);
        end
        start_run(1);
        checks++;
        if ({bus.busy, bus.done, bus.in_ready, bus.pass_cnt, bus.fail_cnt} !== {1'b1, 1'b0, 1'b1, 16'd0}) begin
            errors++;
            $display("FAIL restart_from_done: got busy=%b done=%b rdy=%b pass=%0d fail=%0d required 1 0 1 0 0",
                     bus.busy, bus.done, bus.in_ready, bus.pass_cnt, bus.fail_cnt);
        end
        feed(1'b1, 1'b0, 1'b1, 3'b000);
        checks++;
        if ({bus.fail_cnt, bus.done, bus.mismatch_bits} !== {8'd1, 1'b1, 3'b011}) begin
            errors++;
            $display("FAIL restart_single: got fail=%0d done=%b mb=%b required 1 1 011",
                     bus.fail_cnt, bus.done, bus.mismatch_bits);
        end
    endtask

    task automatic test_async_reset();
        start_run(4);
        feed(1'b1, 1'b1, 1'b0, 3'b101);
        feed(1'b1, 1'b0, 1'b1, 3'b100);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.busy, bus.done, bus.mismatch, bus.pass_cnt, bus.fail_cnt,
             bus.mismatch_bits, bus.last_fail_vec} !== 29'd0) begin
            errors++;
            $display("FAIL async_reset: got rdy=%b busy=%b done=%b mis=%b pass=%0d fail=%0d mb=%b lfv=%b required all 0",
                     bus.in_ready, bus.busy, bus.done, bus.mismatch, bus.pass_cnt, bus.fail_cnt,
                     bus.mismatch_bits, bus.last_fail_vec);
        end
        #1 rst_n = 1'b1;
        m_run = 0; m_done = 0; model_clear();
        bus.in_valid = 1'b1;
        tick(); tick();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.in_ready, bus.pass_cnt, bus.fail_cnt} !== 19'd0) begin
            errors++;
            $display("FAIL post_reset_idle: got busy=%b done=%b rdy=%b pass=%0d fail=%0d required 0",
                     bus.busy, bus.done, bus.in_ready, bus.pass_cnt, bus.fail_cnt);
        end
    endtask

    task automatic test_clear();
        start_run(4);
        feed(1'b1, 1'b1, 1'b1, 3'b000);
        feed(1'b1, 1'b0, 1'b0, 3'b001);
        bus.clear = 1'b1; bus.start = 1'b1; bus.num_vec = 8'd5; bus.in_valid = 1'b1;
        tick();
        bus.clear = 1'b0; bus.start = 1'b0; bus.in_valid = 1'b0;
        m_run = 0; m_done = 0; model_clear();
        checks++;
        if ({bus.busy, bus.done, bus.in_ready, bus.mismatch, bus.pass_cnt, bus.fail_cnt,
             bus.mismatch_bits, bus.last_fail_vec} !== 28'd0) begin
            errors++;
            $display("FAIL clear_mid_run: got busy=%b done=%b rdy=%b mis=%b pass=%0d fail=%0d mb=%b lfv=%b required all 0",
                     bus.busy, bus.done, bus.in_ready, bus.mismatch, bus.pass_cnt, bus.fail_cnt,
                     bus.mismatch_bits, bus.last_fail_vec);
        end
    endtask

    task automatic test_random();
        bit a, b, v;
        logic [2:0] y;
        int n, guard;
        for (int r = 0; r < 15; r++) begin
            n = $urandom_range(1, 12);
            start_run(n);
            guard = 0;
            while (!m_done && guard < 200) begin
                a = 1'($urandom); b = 1'($urandom); v = ($urandom % 4) != 0;
                y = ($urandom % 2) ? {a & b, a | b, !a} : 3'($urandom);
                checks++;
                if (bus.in_ready !== (m_run && m_acc < m_n)) begin
                    errors++;
                    $display("FAIL rand_ready run%0d: got %b required %b", r, bus.in_ready, m_run && m_acc < m_n);
                end
                if ($urandom % 5 == 0) begin
                    bus.start = 1'b1; bus.num_vec = 8'($urandom);
                end
                feed(v, a, b, y);
                bus.start = 1'b0;
                checks++;
                if ({bus.pass_cnt, bus.fail_cnt, bus.mismatch, bus.done, bus.busy, bus.mismatch_bits, bus.last_fail_vec}
                    !== {8'(m_pass), 8'(m_fail), m_mis, m_done, m_run, m_mbits, m_lfv}) begin
                    errors++;
                    $display("FAIL rand_state run%0d: got pass=%0d fail=%0d mis=%b done=%b busy=%b mb=%b lfv=%b required %0d %0d %b %b %b %b %b",
                             r, bus.pass_cnt, bus.fail_cnt, bus.mismatch, bus.done, bus.busy, bus.mismatch_bits,
                             bus.last_fail_vec, m_pass, m_fail, m_mis, m_done, m_run, m_mbits, m_lfv);
                end
                guard++;
            end
            if (guard >= 200) begin
                errors++; checks++;
                $display("FAIL rand_timeout run%0d: got no done required done", r);
            end
        end
    endtask

    task automatic test_saturation();
        bus2.start = 1'b1; bus2.num_vec = 2'd3;
        tick();
        bus2.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus2.in_valid = 1'b1; bus2.a = 1'b0; bus2.b = 1'b0; bus2.y = 3'b000;
            tick();
            checks++;
            if (bus2.fail_cnt !== 2'(i + 1)) begin
                errors++;
                $display("FAIL sat_count vec%0d: got fail=%0d required %0d", i, bus2.fail_cnt, i + 1);
            end
        end
        tick();
        bus2.in_valid = 1'b0;
        checks++;
        if ({bus2.fail_cnt, bus2.pass_cnt, bus2.done, bus2.in_ready} !== {2'd3, 2'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sat_no_wrap: got fail=%0d pass=%0d done=%b rdy=%b required 3 0 1 0",
                     bus2.fail_cnt, bus2.pass_cnt, bus2.done, bus2.in_ready);
        end
        bus2.start = 1'b1; bus2.num_vec = 2'd3;
        tick();
        bus2.start = 1'b0;
        checks++;
        if ({bus2.fail_cnt, bus2.pass_cnt, bus2.busy} !== {2'd0, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL sat_restart: got fail=%0d pass=%0d busy=%b required 0 0 1",
                     bus2.fail_cnt, bus2.pass_cnt, bus2.busy);
        end
    endtask

    initial begin
        bus.start = 0; bus.num_vec = '0; bus.clear = 0; bus.in_valid = 0;
        bus.a = 0; bus.b = 0; bus.y = '0;
        bus2.start = 0; bus2.num_vec = '0; bus2.clear = 0; bus2.in_valid = 0;
        bus2.a = 0; bus2.b = 0; bus2.y = '0;
        test_reset();
        test_back_to_back();
        test_one_fail();
        test_gapped_valid();
        test_zero_restart();
        test_async_reset();
        test_clear();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
